// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the shared UART1 TX byte port.
// Optional debug probe enabled by defining UART_ARB_DEBUG_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   timeout_evt,
  output logic [3:0]             debug
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    START = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_q, last_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tevt_nxt;

  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;

  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  // First valid requester after the last owner, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    pick_hit = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!pick_hit && req_valid[IDX_W'(cand)]) begin
        pick_hit = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Owner's byte lane, selected by the one-hot grant.
  always_comb begin : owner_mux
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == LOCK && !tx_busy) ? grant : '0;
  assign tx_start  = (state == START);

  always_comb begin : fsm_comb
    state_nxt   = state;
    grant_nxt   = grant;
    gidx_nxt    = gidx;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    last_nxt    = last_q;
    tx_data_nxt = tx_data;
    tevt_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_hit) begin
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          gidx_nxt            = pick_idx;
          state_nxt           = LOCK;
        end
      end
      LOCK: begin
        if (sel_valid && !tx_busy) begin
          tx_data_nxt = sel_data;
          last_nxt    = sel_last;
          cnt_nxt     = '0;
          state_nxt   = START;
        end else if (!sel_valid) begin
          // Owner stalled: count towards revocation, saturating at the limit.
          if (cnt == CNT_MAX) begin
            grant_nxt = '0;
            ptr_nxt   = gidx;
            tevt_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      START: state_nxt = DRAIN;
      DRAIN: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_nxt = '0;
            ptr_nxt   = gidx;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOCK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin : fsm_reg
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      ptr         <= PTR_RST;
      cnt         <= '0;
      last_q      <= 1'b0;
      tx_data     <= 8'h00;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      gidx        <= gidx_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      last_q      <= last_nxt;
      tx_data     <= tx_data_nxt;
      timeout_evt <= tevt_nxt;
    end
  end

`ifdef UART_ARB_DEBUG_EN
  // One-cycle-lagged probe for logic-analyzer capture on sys_clk.
  always_ff @(posedge sys_clk) begin : dbg_reg
    if (rst) debug <= 4'h0;
    else     debug <= {state, last_q, tx_busy};
  end
`else
  assign debug = 4'h0;
`endif

endmodule
